// File: rtl/dac_pkg.sv
// Shared command codes and scheduler FSM states for the DAC channel scheduler.
package dac_pkg;

  typedef enum logic [1:0] {
    StIdle     = 2'd0,
    StIssue    = 2'd1,
    StWaitDone = 2'd2
  } state_e;

  localparam logic [3:0] CMD_WRITE         = 4'b0000;
  localparam logic [3:0] CMD_WRITE_UPD_ALL = 4'b0010;
  localparam logic [3:0] CMD_WRITE_UPD     = 4'b0011;

endpackage

// File: rtl/rr_arbiter4.sv
// Four-way round-robin pick: first set request bit at or after pointer, wrapping.
module rr_arbiter4 (
  input  logic [3:0] request,
  input  logic [1:0] pointer,
  output logic [1:0] grant,
  output logic       any
);

  // Walk offsets from farthest to nearest so the nearest requester wins last.
  always_comb begin
    grant = pointer;
    any   = 1'b0;
    for (int k = 3; k >= 0; k--) begin
      if (request[pointer + 2'(k)]) begin
        grant = pointer + 2'(k);
        any   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dac_channel_scheduler.sv
// Buffers one sample per DAC channel and issues SPI frames in round-robin order,
// aborting a frame that never completes and flagging it as a sticky timeout.
module dac_channel_scheduler
  import dac_pkg::*;
#(
  parameter int unsigned DATA_W      = 12,
  parameter int unsigned TIMEOUT     = 255,
  parameter bit          SYNC_UPDATE = 1'b0
) (
  input  logic                CLK_IN,
  input  logic                RST_N,
  input  logic [3:0]          REQ_VALID,
  input  logic [4*DATA_W-1:0] REQ_DATA,
  output logic [3:0]          REQ_READY,
  output logic                DAC_START,
  output logic [3:0]          DAC_CMD,
  output logic [3:0]          DAC_ADDR,
  output logic [DATA_W-1:0]   DAC_DATA,
  input  logic                DAC_BUSY,
  input  logic                DAC_DONE,
  input  logic                ERR_CLR,
  output logic                ERR_TIMEOUT,
  output logic [1:0]          GRANT
);

  state_e            state_q, state_d;
  logic [3:0]        pending_q;
  logic [DATA_W-1:0] slot_q [4];
  logic [1:0]        ptr_q, ptr_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [1:0]        grant_q, grant_d;
  logic [3:0]        cmd_q, cmd_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              err_q, err_d;
  logic [3:0]        clr_mask;

  logic [3:0]        accept, eligible, others;
  logic [1:0]        win;
  logic              win_any;
  logic [DATA_W-1:0] win_data;

  assign accept   = REQ_VALID & ~pending_q;
  // Same-edge arrivals are eligible so an idle scheduler starts the very next cycle.
  assign eligible = pending_q | accept;
  assign others   = eligible & ~(4'b0001 << win);
  assign win_data = pending_q[win] ? slot_q[win] : REQ_DATA[win*DATA_W +: DATA_W];

  rr_arbiter4 u_arb (
    .request (eligible),
    .pointer (ptr_q),
    .grant   (win),
    .any     (win_any)
  );

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    grant_d  = grant_q;
    cmd_d    = cmd_q;
    data_d   = data_q;
    clr_mask = 4'b0000;
    err_d    = err_q & ~ERR_CLR;
    unique case (state_q)
      StIdle: begin
        if (win_any && !DAC_BUSY) begin
          grant_d = win;
          data_d  = win_data;
          if (SYNC_UPDATE) cmd_d = (|others) ? CMD_WRITE : CMD_WRITE_UPD_ALL;
          else             cmd_d = CMD_WRITE_UPD;
          state_d = StIssue;
        end
      end
      StIssue: begin
        cnt_d   = 8'd0;
        state_d = StWaitDone;
      end
      StWaitDone: begin
        if (DAC_DONE || cnt_q == 8'(TIMEOUT - 1)) begin
          if (!DAC_DONE) err_d = 1'b1;
          clr_mask[grant_q] = 1'b1;
          ptr_d   = grant_q + 2'd1;
          cnt_d   = 8'd0;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK_IN or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= StIdle;
      pending_q <= 4'b0000;
      ptr_q     <= 2'd0;
      cnt_q     <= 8'd0;
      grant_q   <= 2'd0;
      cmd_q     <= 4'b0000;
      data_q    <= '0;
      err_q     <= 1'b0;
      for (int i = 0; i < 4; i++) slot_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= (pending_q & ~clr_mask) | accept;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      grant_q   <= grant_d;
      cmd_q     <= cmd_d;
      data_q    <= data_d;
      err_q     <= err_d;
      for (int i = 0; i < 4; i++) begin
        if (accept[i]) slot_q[i] <= REQ_DATA[i*DATA_W +: DATA_W];
      end
    end
  end

  assign REQ_READY   = ~pending_q;
  assign DAC_START   = (state_q == StIssue);
  assign DAC_CMD     = cmd_q;
  assign DAC_ADDR    = {2'b00, grant_q};
  assign DAC_DATA    = data_q;
  assign ERR_TIMEOUT = err_q;
  assign GRANT       = grant_q;

endmodule

// File: tb/tb_dac_channel_scheduler.sv
// Directed and random stimulus for two scheduler instances (immediate and deferred update)
// checked every cycle against a transaction-level reference model.
module tb_dac_channel_scheduler;

  localparam int DW = 12;
  localparam int TO = 255;

  logic          CLK_IN = 1'b0;
  logic          RST_N;
  logic [3:0]    req_valid;
  logic [4*DW-1:0] req_data;
  logic          dac_busy, dac_done, err_clr;

  logic [3:0]    d0_ready, d0_cmd, d0_addr, d1_ready, d1_cmd, d1_addr;
  logic          d0_start, d0_err, d1_start, d1_err;
  logic [DW-1:0] d0_data, d1_data;
  logic [1:0]    d0_grant, d1_grant;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 CLK_IN = ~CLK_IN;

  dac_channel_scheduler #(.DATA_W(DW), .TIMEOUT(TO), .SYNC_UPDATE(1'b0)) u_dut (
    .CLK_IN(CLK_IN), .RST_N(RST_N), .REQ_VALID(req_valid), .REQ_DATA(req_data),
    .REQ_READY(d0_ready), .DAC_START(d0_start), .DAC_CMD(d0_cmd), .DAC_ADDR(d0_addr),
    .DAC_DATA(d0_data), .DAC_BUSY(dac_busy), .DAC_DONE(dac_done), .ERR_CLR(err_clr),
    .ERR_TIMEOUT(d0_err), .GRANT(d0_grant)
  );

  dac_channel_scheduler #(.DATA_W(DW), .TIMEOUT(TO), .SYNC_UPDATE(1'b1)) u_sync (
    .CLK_IN(CLK_IN), .RST_N(RST_N), .REQ_VALID(req_valid), .REQ_DATA(req_data),
    .REQ_READY(d1_ready), .DAC_START(d1_start), .DAC_CMD(d1_cmd), .DAC_ADDR(d1_addr),
    .DAC_DATA(d1_data), .DAC_BUSY(dac_busy), .DAC_DONE(dac_done), .ERR_CLR(err_clr),
    .ERR_TIMEOUT(d1_err), .GRANT(d1_grant)
  );

  // Reference model: phase 0 = idle, 1 = frame being issued, 2 = awaiting completion.
  bit [3:0] m_pend;
  int       m_slot [4];
  int       m_ptr, m_phase, m_gnt, m_data, m_cmd0, m_cmd1, m_waited;
  bit       m_err;

  task automatic model_reset();
    m_pend = 4'b0000;
    for (int i = 0; i < 4; i++) m_slot[i] = 0;
    m_ptr = 0; m_phase = 0; m_gnt = 0; m_data = 0; m_cmd0 = 0; m_cmd1 = 0; m_waited = 0;
    m_err = 1'b0;
  endtask

  task automatic model_edge();
    bit [3:0] acc, elig, clr;
    bit       set_err, found;
    int       w;
    acc = req_valid & ~m_pend;
    elig = m_pend | acc;
    clr = 4'b0000;
    set_err = 1'b0;
    found = 1'b0;
    w = 0;
    if (m_phase == 0) begin
      if (elig != 4'b0000 && !dac_busy) begin
        for (int k = 0; k < 4; k++) begin
          if (!found && elig[(m_ptr + k) % 4]) begin
            w = (m_ptr + k) % 4;
            found = 1'b1;
          end
        end
        m_gnt  = w;
        m_data = m_pend[w] ? m_slot[w] : int'(req_data[w*DW +: DW]);
        m_cmd0 = 3;
        m_cmd1 = ((elig & ~(4'b0001 << w)) != 4'b0000) ? 0 : 2;
        m_phase = 1;
      end
    end else if (m_phase == 1) begin
      m_phase = 2;
      m_waited = 0;
    end else begin
      m_waited++;
      if (dac_done || m_waited >= TO) begin
        if (!dac_done) set_err = 1'b1;
        clr[m_gnt] = 1'b1;
        m_ptr = (m_gnt + 1) % 4;
        m_phase = 0;
      end
    end
    if (set_err) m_err = 1'b1;
    else if (err_clr) m_err = 1'b0;
    for (int i = 0; i < 4; i++) if (acc[i]) m_slot[i] = int'(req_data[i*DW +: DW]);
    m_pend = (m_pend & ~clr) | acc;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s at %0t: observed=%0h expected=%0h", tag, $time, got, exp);
    end
  endtask

  task automatic check_all();
    logic [3:0] rdy;
    rdy = ~m_pend;
    chk("d0_ready", 32'(d0_ready), 32'(rdy));
    chk("d0_start", 32'(d0_start), 32'(m_phase == 1));
    chk("d0_cmd",   32'(d0_cmd),   m_cmd0);
    chk("d0_addr",  32'(d0_addr),  m_gnt);
    chk("d0_grant", 32'(d0_grant), m_gnt);
    chk("d0_data",  32'(d0_data),  m_data);
    chk("d0_err",   32'(d0_err),   32'(m_err));
    chk("d1_ready", 32'(d1_ready), 32'(rdy));
    chk("d1_start", 32'(d1_start), 32'(m_phase == 1));
    chk("d1_cmd",   32'(d1_cmd),   m_cmd1);
    chk("d1_addr",  32'(d1_addr),  m_gnt);
    chk("d1_data",  32'(d1_data),  m_data);
    chk("d1_err",   32'(d1_err),   32'(m_err));
  endtask

  task automatic tick();
    @(posedge CLK_IN);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic do_reset();
    RST_N = 1'b0;
    #1;
    model_reset();
    check_all();
    @(posedge CLK_IN);
    #1;
    RST_N = 1'b1;
  endtask

  task automatic pulse_done();
    dac_done = 1'b1;
    tick();
    dac_done = 1'b0;
  endtask

  task automatic wait_start(input string tag, output int ch);
    int n;
    n = 0;
    while (!d0_start && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_start_seen"}, 32'(d0_start), 32'd1);
    ch = int'(d0_addr);
  endtask

  initial begin
    int ch;
    int n;
    RST_N = 1'b1; req_valid = 4'b0000; req_data = '0;
    dac_busy = 1'b0; dac_done = 1'b0; err_clr = 1'b0;
    #2;
    do_reset();
    chk("reset_ready", 32'(d0_ready), 32'hF);
    tick();

    // Single write to channel 2.
    req_valid = 4'b0100;
    req_data[2*DW +: DW] = 12'hABC;
    tick();
    req_valid = 4'b0000;
    chk("single_start", 32'(d0_start), 32'd1);
    chk("single_cmd",   32'(d0_cmd),   32'h3);
    chk("single_addr",  32'(d0_addr),  32'd2);
    chk("single_data",  32'(d0_data),  32'hABC);
    tick();
    tick();
    pulse_done();
    chk("single_ready2", 32'(d0_ready[2]), 32'd1);

    // All four channels at once, then channel 0 again.
    do_reset();
    req_valid = 4'b1111;
    req_data = {12'h333, 12'h222, 12'h111, 12'h000};
    for (int f = 0; f < 5; f++) begin
      wait_start("rr", ch);
      req_valid = 4'b0000;
      chk("rr_order", ch, f % 4);
      tick();
      pulse_done();
      if (f == 0) begin
        req_valid = 4'b0001;
        req_data[DW-1:0] = 12'h5A5;
      end
    end

    // Deferred update: channel 1 writes only, channel 3 updates all.
    do_reset();
    req_valid = 4'b1010;
    wait_start("sync1", ch);
    req_valid = 4'b0000;
    chk("sync_ch1_addr", 32'(d1_addr), 32'd1);
    chk("sync_ch1_cmd",  32'(d1_cmd),  32'h0);
    tick();
    pulse_done();
    wait_start("sync3", ch);
    chk("sync_ch3_addr", 32'(d1_addr), 32'd3);
    chk("sync_ch3_cmd",  32'(d1_cmd),  32'h2);
    tick();
    pulse_done();

    // Busy engine holds off issue; release issues on the next cycle.
    do_reset();
    dac_busy = 1'b1;
    req_valid = 4'b0001;
    tick();
    req_valid = 4'b0000;
    for (int i = 0; i < 5; i++) tick();
    chk("busy_no_start", 32'(d0_start), 32'd0);
    dac_busy = 1'b0;
    tick();
    chk("busy_release_start", 32'(d0_start), 32'd1);
    tick();
    pulse_done();

    // Timeout on channel 1, then channel 2 served; clear collides with a second timeout.
    do_reset();
    req_valid = 4'b0110;
    tick();
    req_valid = 4'b0000;
    n = 0;
    while (!d0_err && n < 300) begin
      tick();
      n++;
    end
    chk("to_err_set", 32'(d0_err), 32'd1);
    chk("to_slot_freed", 32'(d0_ready[1]), 32'd1);
    tick();
    chk("to_next_start", 32'(d0_start), 32'd1);
    chk("to_next_addr", 32'(d0_addr), 32'd2);
    err_clr = 1'b1;
    tick();
    chk("to_err_clr", 32'(d0_err), 32'd0);
    n = 0;
    while (!d0_err && n < 300) begin
      tick();
      n++;
    end
    chk("to_set_beats_clr", 32'(d0_err), 32'd1);
    tick();
    chk("to_clr_after", 32'(d0_err), 32'd0);
    err_clr = 1'b0;

    // Reset in the middle of a frame discards everything.
    do_reset();
    req_valid = 4'b0110;
    tick();
    req_valid = 4'b0000;
    tick();
    #2;
    RST_N = 1'b0;
    #1;
    model_reset();
    chk("rst_mid_start", 32'(d0_start), 32'd0);
    chk("rst_mid_ready", 32'(d0_ready), 32'hF);
    check_all();
    @(posedge CLK_IN);
    #1;
    RST_N = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    chk("rst_no_frame", 32'(d0_start), 32'd0);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      req_valid = 4'($urandom_range(0, 15) & $urandom_range(0, 15));
      req_data  = 48'({$urandom(), $urandom()});
      dac_busy  = ($urandom_range(0, 4) == 0);
      dac_done  = ($urandom_range(0, 2) == 0);
      err_clr   = ($urandom_range(0, 49) == 0);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, observed=running expected=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
